// File: rtl/lfsr_crypt_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_crypt_engine_if
// Description : Control, status and byte-stream bundle for lfsr_crypt_engine.
//               "master" drives commands and input bytes; "slave" is the engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_crypt_engine_if #(
   parameter int LW   = 7,
   parameter int NPAT = 9
);
   localparam int DW  = LW + 1;
   localparam int PSW = (NPAT > 1) ? $clog2(NPAT) : 1;

   logic           start;
   logic           mode;
   logic [PSW-1:0] pat_sel;
   logic [LW-1:0]  init_state;
   logic [7:0]     len;
   logic           in_valid;
   logic           in_ready;
   logic [DW-1:0]  in_data;
   logic           out_valid;
   logic           out_ready;
   logic [DW-1:0]  out_data;
   logic           ack;
   logic [PSW-1:0] pat_found;
   logic [7:0]     par_err_cnt;
   logic           search_fail;
   logic           ambig;

   modport master (
      output start, mode, pat_sel, init_state, len, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, ack, pat_found, par_err_cnt,
             search_fail, ambig
   );

   modport slave (
      input  start, mode, pat_sel, init_state, len, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, ack, pat_found, par_err_cnt,
             search_fail, ambig
   );
endinterface
`default_nettype wire

// File: rtl/lfsr_crypt_engine.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_crypt_engine
// Description : LFSR stream cipher with parity-carrying bytes. Encrypt uses a
//               selected tap pattern and seed; decrypt recovers the seed from
//               the first pad byte and identifies the tap pattern by tracking
//               all candidates over the leading pad bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_crypt_engine #(
   parameter int LW      = 7,
   parameter int NPAT    = 9,
   parameter logic [NPAT*LW-1:0] TAPS = {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A,
                                         7'h72, 7'h78, 7'h48, 7'h60},
   parameter int PRE_MIN = 10,
   parameter int OFS     = 'h20
) (
   input  logic               clk,
   input  logic               rst,
   lfsr_crypt_engine_if.slave bus
);
   localparam int DW  = LW + 1;
   localparam int PSW = (NPAT > 1) ? $clog2(NPAT) : 1;

   localparam logic [DW-1:0]  c_ofs      = DW'(OFS);
   localparam logic [7:0]     c_pre_last = 8'(PRE_MIN - 1);
   localparam logic [PSW:0]   c_npat     = (PSW + 1)'(NPAT);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] s,
                                               input logic [LW-1:0] tap);
      return {s[LW-2:0], ^(s & tap)};
   endfunction

   function automatic logic [LW-1:0] tap_of(input logic [PSW-1:0] idx);
      logic [LW-1:0] r;
      r = TAPS[LW-1:0];
      for (int k = 0; k < NPAT; k++)
         if (idx == PSW'(k)) r = TAPS[k*LW +: LW];
      return r;
   endfunction

   function automatic logic [PSW-1:0] lowest(input logic [NPAT-1:0] m);
      logic [PSW-1:0] r;
      r = '0;
      for (int k = NPAT - 1; k >= 0; k--)
         if (m[k]) r = PSW'(k);
      return r;
   endfunction

   state_t         state_q, state_d;
   logic           mode_q, mode_d;
   logic [7:0]     len_q, len_d;
   logic [7:0]     in_cnt_q, in_cnt_d;
   logic [7:0]     out_cnt_q, out_cnt_d;
   logic [LW-1:0]  s_q, s_d;
   logic [LW-1:0]  cand_q [NPAT];
   logic [LW-1:0]  cand_d [NPAT];
   logic [NPAT-1:0] alive_q, alive_d;
   logic           search_q, search_d;
   logic [PSW-1:0] pat_q, pat_d;
   logic           out_valid_q, out_valid_d;
   logic [DW-1:0]  out_data_q, out_data_d;
   logic           ack_q, ack_d;
   logic [7:0]     par_err_q, par_err_d;
   logic           search_fail_q, search_fail_d;
   logic           ambig_q, ambig_d;

   logic           w_in_ready, w_in_fire, w_out_fire;
   logic [LW-1:0]  w_pred [NPAT];
   logic [NPAT-1:0] w_match;
   logic [NPAT-1:0] w_new_alive;
   logic [PSW-1:0] w_sel;
   logic [LW-1:0]  w_used;
   logic [LW-1:0]  w_enc_c;

   // Each candidate predicts the next state from its own tap pattern.
   for (genvar k = 0; k < NPAT; k++) begin : g_cand
      assign w_pred[k]  = lfsr_step(cand_q[k], TAPS[k*LW +: LW]);
      assign w_match[k] = (w_pred[k] == bus.in_data[LW-1:0]);
   end

   assign w_in_ready = (state_q == S_RUN) && (!out_valid_q || bus.out_ready) &&
                       (in_cnt_q < len_q);
   assign w_in_fire  = bus.in_valid && w_in_ready;
   assign w_out_fire = out_valid_q && bus.out_ready;

   // Next-state logic: command capture, byte processing and tap search.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      len_d         = len_q;
      in_cnt_d      = in_cnt_q;
      out_cnt_d     = out_cnt_q;
      s_d           = s_q;
      cand_d        = cand_q;
      alive_d       = alive_q;
      search_d      = search_q;
      pat_d         = pat_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      ack_d         = ack_q;
      par_err_d     = par_err_q;
      search_fail_d = search_fail_q;
      ambig_d       = ambig_q;
      w_new_alive   = alive_q & w_match;
      w_sel         = '0;
      w_used        = '0;
      w_enc_c       = '0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               mode_d        = bus.mode;
               len_d         = bus.len;
               in_cnt_d      = 8'd0;
               out_cnt_d     = 8'd0;
               out_valid_d   = 1'b0;
               par_err_d     = 8'd0;
               search_fail_d = 1'b0;
               ambig_d       = 1'b0;
               ack_d         = (bus.len == 8'd0);
               state_d       = (bus.len == 8'd0) ? S_DONE : S_RUN;
               if (!bus.mode) begin
                  pat_d    = ({1'b0, bus.pat_sel} < c_npat) ? bus.pat_sel : '0;
                  s_d      = (bus.init_state == '0) ? LW'(1) : bus.init_state;
                  search_d = 1'b0;
               end else begin
                  pat_d    = '0;
                  s_d      = '0;
                  search_d = 1'b1;
                  alive_d  = '1;
               end
            end
         end

         S_RUN: begin
            if (w_out_fire) begin
               out_valid_d = 1'b0;
               out_cnt_d   = out_cnt_q + 8'd1;
               if (out_cnt_q == len_q - 8'd1) begin
                  state_d = S_DONE;
                  ack_d   = 1'b1;
               end
            end
            if (w_in_fire) begin
               in_cnt_d    = in_cnt_q + 8'd1;
               out_valid_d = 1'b1;
               if (!mode_q) begin
                  w_enc_c    = (bus.in_data[LW-1:0] - c_ofs[LW-1:0]) ^ s_q;
                  out_data_d = {^w_enc_c, w_enc_c};
                  s_d        = lfsr_step(s_q, tap_of(pat_q));
               end else begin
                  if ((bus.in_data[DW-1] != ^bus.in_data[LW-1:0]) && (par_err_q != 8'hFF))
                     par_err_d = par_err_q + 8'd1;
                  if (search_q) begin
                     if (in_cnt_q == 8'd0) begin
                        // First pad byte exposes the state directly.
                        w_new_alive = alive_q;
                        for (int k = 0; k < NPAT; k++) cand_d[k] = bus.in_data[LW-1:0];
                        w_used = bus.in_data[LW-1:0];
                        w_sel  = lowest(w_new_alive);
                     end else begin
                        for (int k = 0; k < NPAT; k++) cand_d[k] = w_pred[k];
                        if (w_new_alive == '0) begin
                           // Nobody matched: keep the best guess from before.
                           w_sel         = lowest(alive_q);
                           search_fail_d = 1'b1;
                        end else begin
                           w_sel = lowest(w_new_alive);
                        end
                        for (int k = 0; k < NPAT; k++)
                           if (w_sel == PSW'(k)) w_used = w_pred[k];
                     end
                     alive_d = w_new_alive;
                     if ((w_new_alive == '0) || (in_cnt_q == c_pre_last) ||
                         (in_cnt_q == len_q - 8'd1)) begin
                        search_d = 1'b0;
                        pat_d    = w_sel;
                        ambig_d  = |(w_new_alive & (w_new_alive - NPAT'(1)));
                        s_d      = lfsr_step(w_used, tap_of(w_sel));
                     end
                  end else begin
                     w_used = s_q;
                     s_d    = lfsr_step(s_q, tap_of(pat_q));
                  end
                  out_data_d = {1'b0, bus.in_data[LW-1:0] ^ w_used} + c_ofs;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         mode_q        <= 1'b0;
         len_q         <= 8'd0;
         in_cnt_q      <= 8'd0;
         out_cnt_q     <= 8'd0;
         s_q           <= '0;
         for (int k = 0; k < NPAT; k++) cand_q[k] <= '0;
         alive_q       <= '0;
         search_q      <= 1'b0;
         pat_q         <= '0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         ack_q         <= 1'b0;
         par_err_q     <= 8'd0;
         search_fail_q <= 1'b0;
         ambig_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         len_q         <= len_d;
         in_cnt_q      <= in_cnt_d;
         out_cnt_q     <= out_cnt_d;
         s_q           <= s_d;
         cand_q        <= cand_d;
         alive_q       <= alive_d;
         search_q      <= search_d;
         pat_q         <= pat_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         ack_q         <= ack_d;
         par_err_q     <= par_err_d;
         search_fail_q <= search_fail_d;
         ambig_q       <= ambig_d;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_data    = out_data_q;
   assign bus.ack         = ack_q;
   assign bus.pat_found   = pat_q;
   assign bus.par_err_cnt = par_err_q;
   assign bus.search_fail = search_fail_q;
   assign bus.ambig       = ambig_q;
endmodule
`default_nettype wire

// File: tb/tb_lfsr_crypt_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_crypt_engine
// Description : Directed self-checking bench for lfsr_crypt_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_crypt_engine;
   localparam int LW   = 7;
   localparam int NPAT = 9;
   localparam int N    = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lfsr_crypt_engine_if #(.LW(LW), .NPAT(NPAT)) bus ();
   lfsr_crypt_engine #(.LW(LW), .NPAT(NPAT)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errors = 0;
   int checks = 0;

   logic [7:0] plain  [N];
   logic [7:0] cipher [N];
   logic [7:0] in_buf [N];
   logic [7:0] out_buf[N];
   int         out_cnt;
   int         stall_viol;

   function automatic logic [6:0] m_step(input logic [6:0] s, input logic [6:0] t);
      return {s[5:0], ^(s & t)};
   endfunction

   // Reference plaintext (19 pad bytes, "Ajok", trailing pad) and its ciphertext.
   task automatic build_vectors();
      logic [6:0] s, c;
      for (int i = 0; i < N; i++) plain[i] = 8'h20;
      plain[19] = 8'h41; plain[20] = 8'h6A; plain[21] = 8'h6F; plain[22] = 8'h6B;
      s = 7'h16;
      for (int i = 0; i < N; i++) begin
         c         = (plain[i][6:0] - 7'h20) ^ s;
         cipher[i] = {^c, c};
         s         = m_step(s, 7'h7B);
      end
   endtask

   // Launch a run from a negedge and move bytes until len outputs (or abort_at).
   task automatic run_stream(input bit md, input logic [3:0] ps, input logic [6:0] seed,
                             input int len, input bit throttle, input int abort_at);
      int         in_idx = 0;
      int         cyc    = 0;
      bit         in_fire = 0, stalled = 0;
      logic [7:0] held = 8'h00;
      out_cnt    = 0;
      stall_viol = 0;
      bus.mode = md; bus.pat_sel = ps; bus.init_state = seed; bus.len = 8'(len);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      while (out_cnt < len && out_cnt != abort_at && cyc < 2000) begin
         if (in_fire) in_idx++;
         if (stalled && (bus.out_valid !== 1'b1 || bus.out_data !== held)) stall_viol++;
         bus.in_valid  = (in_idx < len) && (!throttle || $urandom_range(0, 1) == 1);
         bus.in_data   = (in_idx < len) ? in_buf[in_idx] : 8'h00;
         bus.out_ready = !throttle || ($urandom_range(0, 2) != 0);
         #1;
         in_fire = bus.in_valid && bus.in_ready;
         if (bus.out_valid && bus.out_ready) begin
            out_buf[out_cnt] = bus.out_data;
            out_cnt++;
         end
         stalled = bus.out_valid && !bus.out_ready;
         held    = bus.out_data;
         cyc++;
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.ack, bus.search_fail, bus.ambig} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 00000",
                  {bus.in_ready, bus.out_valid, bus.ack, bus.search_fail, bus.ambig});
      end
      checks++;
      if ({bus.pat_found, bus.par_err_cnt} !== 12'h000) begin
         errors++;
         $display("FAIL reset_counts: got pat=%0d par=%0d want 0/0", bus.pat_found, bus.par_err_cnt);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL idle_in_ready: got %b want 0", bus.in_ready);
      end
   endtask

   task automatic test_encrypt_vector();
      in_buf[0] = 8'h20; in_buf[1] = 8'h20;
      run_stream(1'b0, 4'd8, 7'h16, 2, 1'b0, -1);
      checks++;
      if (out_cnt !== 2) begin errors++; $display("FAIL encv_count: got %0d want 2", out_cnt); end
      checks++;
      if (out_buf[0] !== 8'h96) begin errors++; $display("FAIL encv_b0: got %h want 96", out_buf[0]); end
      checks++;
      if (out_buf[1] !== 8'hAC) begin errors++; $display("FAIL encv_b1: got %h want ac", out_buf[1]); end
      checks++;
      if (bus.ack !== 1'b1) begin errors++; $display("FAIL encv_ack: got %b want 1", bus.ack); end
      checks++;
      if (bus.pat_found !== 4'd8) begin errors++; $display("FAIL encv_pat: got %0d want 8", bus.pat_found); end
   endtask

   task automatic test_encrypt_stream();
      for (int i = 0; i < N; i++) in_buf[i] = plain[i];
      run_stream(1'b0, 4'd8, 7'h16, N, 1'b0, -1);
      checks++;
      if (out_cnt !== N) begin errors++; $display("FAIL enc_count: got %0d want %0d", out_cnt, N); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_buf[i] !== cipher[i]) begin
            errors++;
            $display("FAIL enc_byte%0d: got %h want %h", i, out_buf[i], cipher[i]);
         end
      end
   endtask

   task automatic test_decrypt();
      for (int i = 0; i < N; i++) in_buf[i] = cipher[i];
      run_stream(1'b1, 4'd0, 7'h00, N, 1'b0, -1);
      checks++;
      if (out_cnt !== N) begin errors++; $display("FAIL dec_count: got %0d want %0d", out_cnt, N); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (out_buf[i] !== plain[i]) begin
            errors++;
            $display("FAIL dec_byte%0d: got %h want %h", i, out_buf[i], plain[i]);
         end
      end
      checks++;
      if ({bus.ack, bus.pat_found, bus.search_fail, bus.ambig} !== {1'b1, 4'd8, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL dec_status: got ack=%b pat=%0d fail=%b ambig=%b want 1/8/0/0",
                  bus.ack, bus.pat_found, bus.search_fail, bus.ambig);
      end
      checks++;
      if (bus.par_err_cnt !== 8'd0) begin errors++; $display("FAIL dec_par: got %0d want 0", bus.par_err_cnt); end
   endtask

   task automatic test_parity();
      int bad = 0;
      for (int i = 0; i < N; i++) in_buf[i] = cipher[i];
      in_buf[5] = in_buf[5] ^ 8'h80;
      run_stream(1'b1, 4'd0, 7'h00, N, 1'b0, -1);
      for (int i = 0; i < N; i++) if (out_buf[i] !== plain[i]) bad++;
      checks++;
      if (out_cnt !== N || bad != 0) begin
         errors++;
         $display("FAIL par_data: got count=%0d bad=%0d want %0d/0", out_cnt, bad, N);
      end
      checks++;
      if (bus.par_err_cnt !== 8'd1) begin errors++; $display("FAIL par_count: got %0d want 1", bus.par_err_cnt); end
   endtask

   task automatic test_throttle();
      int bad = 0;
      for (int i = 0; i < N; i++) in_buf[i] = cipher[i];
      run_stream(1'b1, 4'd0, 7'h00, N, 1'b1, -1);
      for (int i = 0; i < N; i++) if (out_buf[i] !== plain[i]) bad++;
      checks++;
      if (out_cnt !== N || bad != 0) begin
         errors++;
         $display("FAIL thr_data: got count=%0d bad=%0d want %0d/0", out_cnt, bad, N);
      end
      checks++;
      if (stall_viol != 0) begin errors++; $display("FAIL thr_stable: got %0d violations want 0", stall_viol); end
      checks++;
      if ({bus.ack, bus.pat_found, bus.par_err_cnt} !== {1'b1, 4'd8, 8'd0}) begin
         errors++;
         $display("FAIL thr_status: got ack=%b pat=%0d par=%0d want 1/8/0",
                  bus.ack, bus.pat_found, bus.par_err_cnt);
      end
   endtask

   task automatic test_search_fail();
      for (int i = 0; i < N; i++) in_buf[i] = cipher[i];
      in_buf[3] = in_buf[3] ^ 8'h40;
      run_stream(1'b1, 4'd0, 7'h00, N, 1'b0, -1);
      checks++;
      if (out_cnt !== N || bus.ack !== 1'b1) begin
         errors++;
         $display("FAIL sf_done: got count=%0d ack=%b want %0d/1", out_cnt, bus.ack, N);
      end
      checks++;
      if ({bus.search_fail, bus.ambig, bus.pat_found} !== {1'b1, 1'b0, 4'd5}) begin
         errors++;
         $display("FAIL sf_status: got fail=%b ambig=%b pat=%0d want 1/0/5",
                  bus.search_fail, bus.ambig, bus.pat_found);
      end
   endtask

   task automatic test_short_search();
      in_buf[0] = cipher[0]; in_buf[1] = cipher[1];
      run_stream(1'b1, 4'd0, 7'h00, 2, 1'b0, -1);
      checks++;
      if (out_cnt !== 2 || out_buf[0] !== 8'h20 || out_buf[1] !== 8'h20) begin
         errors++;
         $display("FAIL short_data: got count=%0d %h %h want 2 20 20", out_cnt, out_buf[0], out_buf[1]);
      end
      checks++;
      if ({bus.ambig, bus.search_fail, bus.pat_found, bus.ack} !== {1'b1, 1'b0, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL short_status: got ambig=%b fail=%b pat=%0d ack=%b want 1/0/0/1",
                  bus.ambig, bus.search_fail, bus.pat_found, bus.ack);
      end
   endtask

   task automatic test_reset_mid_run();
      for (int i = 0; i < N; i++) in_buf[i] = cipher[i];
      run_stream(1'b1, 4'd0, 7'h00, N, 1'b0, 30);
      checks++;
      if (out_cnt !== 30) begin errors++; $display("FAIL mid_progress: got %0d want 30", out_cnt); end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.in_ready, bus.out_valid, bus.ack, bus.search_fail, bus.ambig,
           bus.pat_found, bus.par_err_cnt} !== 17'h0) begin
         errors++;
         $display("FAIL mid_reset: got rdy=%b vld=%b ack=%b pat=%0d par=%0d want all 0",
                  bus.in_ready, bus.out_valid, bus.ack, bus.pat_found, bus.par_err_cnt);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.in_ready, bus.ack} !== 2'b00) begin
         errors++;
         $display("FAIL post_reset: got rdy=%b ack=%b want 0/0", bus.in_ready, bus.ack);
      end
      bus.mode = 1'b0; bus.len = 8'd0; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.ack !== 1'b1) begin errors++; $display("FAIL len0_ack: got %b want 1", bus.ack); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.start = 1'b0; bus.mode = 1'b0; bus.pat_sel = '0; bus.init_state = '0;
      bus.len = 8'd0; bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b0;
      build_vectors();
      test_reset();
      test_encrypt_vector();
      test_encrypt_stream();
      test_decrypt();
      test_parity();
      test_throttle();
      test_search_fail();
      test_short_search();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
